// File: rtl/sonar_echo_capture_pkg.sv
// Shared bus widths, register map and control/status bit positions for the sonar echo capture block.
package sonar_echo_capture_pkg;

    localparam int unsigned BUS_WIDTH = 16;
    localparam int unsigned ADR_WIDTH = 4;

    typedef enum logic [ADR_WIDTH-1:0] {
        ECAP_CONTROL    = 4'h0,
        ECAP_STATUS     = 4'h1,
        ECAP_TIMEOUT_LO = 4'h2,
        ECAP_TIMEOUT_HI = 4'h3,
        ECAP_EVT_CH     = 4'h4,
        ECAP_EVT_TS_LO  = 4'h5,
        ECAP_EVT_TS_HI  = 4'h6,
        ECAP_ARMED      = 4'h7,
        ECAP_TS_LO      = 4'h8,
        ECAP_TS_HI      = 4'h9
    } ecap_reg_e;

    localparam int unsigned CTRL_ENABLE   = 0;
    localparam int unsigned CTRL_IRQ_EN   = 1;
    localparam int unsigned CTRL_SOFT_ARM = 2;
    localparam int unsigned STAT_OVERFLOW = 2;

    // Channel-index field width; a single channel still gets one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sonar_echo_capture_if.sv
// Register-bus request signals shared by the firmware-side master and the capture block.
interface sonar_echo_capture_if;
    import sonar_echo_capture_pkg::*;

    logic                 wb_valid_i;
    logic [ADR_WIDTH-1:0] wbs_adr_i;
    logic [BUS_WIDTH-1:0] wbs_dat_i;
    logic                 wbs_strb_i;

    modport master (output wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i);
    modport slave  (input  wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i);

endinterface

// File: rtl/sonar_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds when a pop happens on the same edge.
module sonar_evt_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sonar_echo_capture.sv
// Timestamps the first rising edge of each armed sonar channel and queues {channel, timestamp}
// events for firmware to read over the 16-bit register bus.
module sonar_echo_capture
    import sonar_echo_capture_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned TS_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    sonar_echo_capture_if.slave   bus,
    output wire                   wbs_ack_o,
    output wire  [BUS_WIDTH-1:0]  wbs_dat_o,
    output logic                  hi_z,
    input  logic                  ce_pcm,
    input  logic                  mclear,
    input  logic [N_CH-1:0]       cmp_i,
    output logic                  irq
);

    localparam int unsigned CH_W  = ch_width(N_CH);
    localparam int unsigned EVT_W = CH_W + TS_WIDTH;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 ack_q;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_c;
    logic                 enable_q, irq_en_q, overflow_q;
    logic                 done_q, done_d;
    logic [BUS_WIDTH-1:0] tmo_lo_q, tmo_hi_q;
    logic [TS_WIDTH-1:0]  ts_q, ts_d, timeout_c;
    logic [TS_WIDTH-1:0]  ts_cap_q [N_CH];
    logic [N_CH-1:0]      armed_q, armed_d, pending_q, pending_d, cmp_dly_q, rise_c;

    logic                 access_c, wr_c, rd_c, arm_c, hit_c, push_c, pop_c, ovf_set_c;
    logic [CH_W-1:0]      push_ch_c;
    logic [EVT_W-1:0]     head;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [31:0]          ts32_c, head_ts32_c;

    assign access_c    = bus.wb_valid_i & ~ack_q;
    assign wr_c        = access_c & bus.wbs_strb_i;
    assign rd_c        = access_c & ~bus.wbs_strb_i;
    assign timeout_c   = TS_WIDTH'({tmo_hi_q, tmo_lo_q});
    assign ts32_c      = 32'(ts_q);
    assign head_ts32_c = 32'(head[TS_WIDTH-1:0]);

    // Arm, timeout, edge detect and lowest-index-first event arbitration.
    always_comb begin
        arm_c = (mclear & enable_q)
              | (wr_c && bus.wbs_adr_i == ECAP_CONTROL
                 && bus.wbs_dat_i[CTRL_SOFT_ARM] && bus.wbs_dat_i[CTRL_ENABLE]);
        hit_c  = (timeout_c != '0) && (ts_q == timeout_c) && !done_q;
        rise_c = cmp_i & ~cmp_dly_q & armed_q & {N_CH{enable_q & ~arm_c}};
        pop_c  = rd_c && (bus.wbs_adr_i == ECAP_EVT_TS_HI);

        push_c    = |pending_q;
        push_ch_c = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (pending_q[i]) push_ch_c = CH_W'(i);
        end
        ovf_set_c = push_c & fifo_full & ~pop_c;

        pending_d = pending_q;
        if (push_c) pending_d[push_ch_c] = 1'b0;
        pending_d = pending_d | rise_c;

        armed_d = armed_q & ~rise_c;
        done_d  = done_q;
        ts_d    = ts_q;
        if (hit_c) begin
            armed_d = '0;
            done_d  = 1'b1;
        end else if (enable_q && !done_q && ce_pcm && !(&ts_q)) begin
            ts_d = ts_q + TS_WIDTH'(1);
        end

        if (arm_c) begin
            ts_d      = '0;
            armed_d   = '1;
            pending_d = '0;
            done_d    = 1'b0;
        end
    end

    // Read mux; event registers read zero while the FIFO is empty.
    always_comb begin
        rdata_c = '0;
        case (bus.wbs_adr_i)
            ECAP_CONTROL:    rdata_c = BUS_WIDTH'({irq_en_q, enable_q});
            ECAP_STATUS:     rdata_c = {4'b0, 4'(fifo_count), 4'b0, done_q, overflow_q, fifo_full, fifo_empty};
            ECAP_TIMEOUT_LO: rdata_c = tmo_lo_q;
            ECAP_TIMEOUT_HI: rdata_c = tmo_hi_q;
            ECAP_EVT_CH:     rdata_c = fifo_empty ? '0 : BUS_WIDTH'(head[EVT_W-1 -: CH_W]);
            ECAP_EVT_TS_LO:  rdata_c = fifo_empty ? '0 : head_ts32_c[15:0];
            ECAP_EVT_TS_HI:  rdata_c = fifo_empty ? '0 : head_ts32_c[31:16];
            ECAP_ARMED:      rdata_c = BUS_WIDTH'(armed_q);
            ECAP_TS_LO:      rdata_c = ts32_c[15:0];
            ECAP_TS_HI:      rdata_c = ts32_c[31:16];
            default:         rdata_c = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            tmo_lo_q   <= '0;
            tmo_hi_q   <= '0;
            ts_q       <= '0;
            armed_q    <= '0;
            pending_q  <= '0;
            cmp_dly_q  <= '0;
            for (int c = 0; c < int'(N_CH); c++) ts_cap_q[c] <= '0;
        end else begin
            ack_q     <= access_c;
            if (access_c) rdata_q <= rdata_c;
            ts_q      <= ts_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            cmp_dly_q <= cmp_i;
            for (int c = 0; c < int'(N_CH); c++) begin
                if (rise_c[c]) ts_cap_q[c] <= ts_q;
            end
            if (wr_c) begin
                case (bus.wbs_adr_i)
                    ECAP_CONTROL: begin
                        enable_q <= bus.wbs_dat_i[CTRL_ENABLE];
                        irq_en_q <= bus.wbs_dat_i[CTRL_IRQ_EN];
                    end
                    ECAP_TIMEOUT_LO: tmo_lo_q <= bus.wbs_dat_i;
                    ECAP_TIMEOUT_HI: tmo_hi_q <= bus.wbs_dat_i;
                    default: ;
                endcase
            end
            // A drop on the same edge as a clear leaves overflow set.
            if (ovf_set_c) overflow_q <= 1'b1;
            else if (wr_c && bus.wbs_adr_i == ECAP_STATUS && bus.wbs_dat_i[STAT_OVERFLOW])
                overflow_q <= 1'b0;
        end
    end

    sonar_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  ({push_ch_c, ts_cap_q[push_ch_c]}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign wbs_ack_o = bus.wb_valid_i ? ack_q   : 1'bz;
    assign wbs_dat_o = bus.wb_valid_i ? rdata_q : {BUS_WIDTH{1'bz}};
    assign hi_z      = ~bus.wb_valid_i;
    assign irq       = irq_en_q & ~fifo_empty;

endmodule

// File: tb/tb_sonar_echo_capture.sv
// Scoreboard bench for sonar_echo_capture: bus tasks queue expected read data, a monitor checks on ack.
`timescale 1ns/1ps
module tb_sonar_echo_capture;
    import sonar_echo_capture_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_pcm, mclear;
    logic [3:0]  cmp_i;
    wire         ack;
    wire  [15:0] dat;
    logic        hi_z, irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q  [$];
    logic        chk_q  [$];
    string       name_q [$];

    sonar_echo_capture_if bus_if ();

    sonar_echo_capture #(
        .N_CH       (4),
        .TS_WIDTH   (32),
        .FIFO_DEPTH (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus_if.slave),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat),
        .hi_z      (hi_z),
        .ce_pcm    (ce_pcm),
        .mclear    (mclear),
        .cmp_i     (cmp_i),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per acknowledged access.
    always @(negedge clk) begin : monitor
        logic [15:0] e;
        logic        c;
        string       nm;
        if (bus_if.wb_valid_i && ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: data 0x%0h with nothing expected", dat);
            end else begin
                e  = exp_q.pop_front();
                c  = chk_q.pop_front();
                nm = name_q.pop_front();
                if (c) check(nm, 32'(dat), 32'(e));
            end
        end
    end

    task automatic bus_rd(input logic [3:0] a, input logic [15:0] e, input string nm);
        @(posedge clk); #1;
        bus_if.wb_valid_i = 1'b1;
        bus_if.wbs_strb_i = 1'b0;
        bus_if.wbs_adr_i  = a;
        bus_if.wbs_dat_i  = '0;
        exp_q.push_back(e); chk_q.push_back(1'b1); name_q.push_back(nm);
        @(posedge clk); @(posedge clk); #1;
        bus_if.wb_valid_i = 1'b0;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bus_if.wb_valid_i = 1'b1;
        bus_if.wbs_strb_i = 1'b1;
        bus_if.wbs_adr_i  = a;
        bus_if.wbs_dat_i  = d;
        exp_q.push_back('0); chk_q.push_back(1'b0); name_q.push_back("write");
        @(posedge clk); @(posedge clk); #1;
        bus_if.wb_valid_i = 1'b0;
        bus_if.wbs_strb_i = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 ce_pcm = 1'b1;
            @(posedge clk); #1 ce_pcm = 1'b0;
        end
    endtask

    task automatic arm();
        @(posedge clk); #1 mclear = 1'b1;
        @(posedge clk); #1 mclear = 1'b0;
    endtask

    task automatic rise(input logic [3:0] mask);
        @(posedge clk); #1 cmp_i = cmp_i | mask;
        @(posedge clk); #1 cmp_i = cmp_i & ~mask;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] drain_ch [8];
        logic        a1, a2;
        drain_ch = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd1};

        rst = 1'b1; ce_pcm = 1'b0; mclear = 1'b0; cmp_i = '0;
        bus_if.wb_valid_i = 1'b0; bus_if.wbs_strb_i = 1'b0;
        bus_if.wbs_adr_i = '0; bus_if.wbs_dat_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_hi_z", 32'(hi_z), 32'd1);
        bus_rd(ECAP_STATUS, 16'h0001, "rst_status");
        bus_rd(ECAP_TS_LO,  16'h0000, "rst_ts");
        bus_rd(ECAP_ARMED,  16'h0000, "rst_armed");
        bus_rd(4'hF,        16'h0000, "unmapped_read");

        // Single event on ch2 at ts=5
        bus_wr(ECAP_CONTROL, 16'h0003);
        bus_rd(ECAP_CONTROL, 16'h0003, "control_rb");
        arm();
        bus_rd(ECAP_ARMED, 16'h000F, "armed_all");
        tick(5);
        bus_rd(ECAP_TS_LO, 16'd5, "ts_after_5");
        rise(4'b0100);
        check("irq_one_event", 32'(irq), 32'd1);
        bus_rd(ECAP_ARMED,     16'h000B, "armed_ch2_clear");
        bus_rd(ECAP_STATUS,    16'h0100, "status_count1");
        bus_rd(ECAP_EVT_CH,    16'd2,    "evt_ch2");
        bus_rd(ECAP_EVT_TS_LO, 16'd5,    "evt_ts_lo5");
        bus_rd(ECAP_EVT_TS_HI, 16'd0,    "evt_ts_hi0");
        bus_rd(ECAP_STATUS,    16'h0001, "status_empty_after_pop");
        check("irq_after_pop", 32'(irq), 32'd0);

        // Simultaneous rises on ch3 and ch0 at ts=7
        tick(2);
        rise(4'b1001);
        bus_rd(ECAP_STATUS,    16'h0200, "status_count2");
        bus_rd(ECAP_EVT_CH,    16'd0,    "dual_first_ch");
        bus_rd(ECAP_EVT_TS_LO, 16'd7,    "dual_first_ts");
        bus_rd(ECAP_EVT_TS_HI, 16'd0,    "dual_first_pop");
        bus_rd(ECAP_EVT_CH,    16'd3,    "dual_second_ch");
        bus_rd(ECAP_EVT_TS_LO, 16'd7,    "dual_second_ts");
        bus_rd(ECAP_EVT_TS_HI, 16'd0,    "dual_second_pop");

        // Unarmed rise ignored, re-arm restarts the timestamp
        rise(4'b0001);
        bus_rd(ECAP_STATUS, 16'h0001, "unarmed_ignored");
        arm();
        tick(2);
        rise(4'b0001);
        bus_rd(ECAP_EVT_CH,    16'd0, "rearm_ch0");
        bus_rd(ECAP_EVT_TS_LO, 16'd2, "rearm_ts2");
        bus_rd(ECAP_EVT_TS_HI, 16'd0, "rearm_pop");

        // Fill to 8, then overflow
        arm(); rise(4'b1111);
        arm(); rise(4'b1111);
        bus_rd(ECAP_STATUS, 16'h0802, "status_full");
        check("irq_full", 32'(irq), 32'd1);
        arm(); rise(4'b0001);
        bus_rd(ECAP_STATUS, 16'h0806, "status_overflow");
        bus_wr(ECAP_STATUS, 16'h0004);
        bus_rd(ECAP_STATUS, 16'h0802, "overflow_cleared");

        // Rise lands on the same edge as a pop from a full FIFO
        arm();
        @(posedge clk); #1 cmp_i = 4'b0010;
        bus_rd(ECAP_EVT_TS_HI, 16'd0, "pop_while_full");
        cmp_i = '0;
        repeat (3) @(posedge clk);
        bus_rd(ECAP_STATUS, 16'h0802, "push_pop_no_drop");
        for (int i = 0; i < 8; i++) begin
            bus_rd(ECAP_EVT_CH,    drain_ch[i], $sformatf("drain_ch%0d", i));
            bus_rd(ECAP_EVT_TS_HI, 16'd0,       $sformatf("drain_pop%0d", i));
        end
        bus_rd(ECAP_STATUS, 16'h0001, "drained_empty");

        // Timeout at 3
        bus_wr(ECAP_TIMEOUT_LO, 16'd3);
        bus_wr(ECAP_TIMEOUT_HI, 16'd0);
        bus_rd(ECAP_TIMEOUT_LO, 16'd3, "timeout_rb");
        arm();
        tick(5);
        bus_rd(ECAP_STATUS, 16'h0009, "timeout_done");
        bus_rd(ECAP_TS_LO,  16'd3,    "timeout_ts_held");
        bus_rd(ECAP_ARMED,  16'h0000, "timeout_disarmed");
        rise(4'b0001);
        bus_rd(ECAP_STATUS, 16'h0009, "timeout_rise_ignored");
        bus_wr(ECAP_TIMEOUT_LO, 16'd0);

        // Reset with 3 queued and 2 pending
        arm();
        rise(4'b0111);
        arm();
        tick(2);
        @(posedge clk); #1 cmp_i = 4'b0011;
        @(posedge clk); #1;
        check("irq_before_reset", 32'(irq), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_i = '0;
        check("irq_after_reset", 32'(irq), 32'd0);
        bus_rd(ECAP_STATUS,  16'h0001, "reset_empty");
        bus_rd(ECAP_TS_LO,   16'd0,    "reset_ts");
        bus_rd(ECAP_CONTROL, 16'h0000, "reset_control");
        repeat (4) @(posedge clk);
        bus_rd(ECAP_STATUS,  16'h0001, "reset_no_late_push");

        // Empty pop: zero data, one-cycle ack, count unchanged
        @(posedge clk); #1;
        bus_if.wb_valid_i = 1'b1;
        bus_if.wbs_strb_i = 1'b0;
        bus_if.wbs_adr_i  = ECAP_EVT_TS_HI;
        exp_q.push_back(16'd0); chk_q.push_back(1'b1); name_q.push_back("empty_pop_data");
        @(posedge clk);
        @(negedge clk) a1 = (ack === 1'b1);
        @(negedge clk) a2 = (ack === 1'b1);
        bus_if.wb_valid_i = 1'b0;
        check("empty_pop_ack_pulse", 32'({a1, a2}), 32'b10);
        bus_rd(ECAP_STATUS, 16'h0001, "empty_pop_count0");

        repeat (4) @(posedge clk);
        check("outstanding_reads", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
